// File: rtl/qupls_valid_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : qupls_valid_wr_arbiter_pkg
// Brief   : Shared types for the valid-bit RAM write arbiter slice.
// Revision: 1.0  initial release
// ============================================================================
package qupls_valid_wr_arbiter_pkg;

    localparam int NCHECK = 16;
    localparam int PREGS  = 512;

    typedef logic [$clog2(NCHECK)-1:0] checkpt_ndx_t;
    typedef logic [$clog2(PREGS)-1:0]  pregno_t;

    typedef struct packed {
        logic         vld;
        checkpt_ndx_t cp;
        pregno_t      pr;
        logic         vbit;
        logic         setall;
    } valid_wr_req_t;

    function automatic logic cp_hit(
        input logic         fv,
        input checkpt_ndx_t fcp,
        input checkpt_ndx_t cp
    );
        return fv && (cp == fcp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qupls_valid_wr_arbiter_req_compactor.sv
`default_nettype none
// ============================================================================
// Module  : qupls_req_compactor
// Brief   : Packs asserted request lanes into dense slots, lowest lane first.
// Revision: 1.0  initial release
// ============================================================================
module qupls_req_compactor
    import qupls_valid_wr_arbiter_pkg::*;
#(
    parameter int NSRC = 12
) (
    input  logic          [NSRC-1:0]           i_lane_v,
    input  valid_wr_req_t [NSRC-1:0]           i_lane,
    output valid_wr_req_t [NSRC-1:0]           o_slot,
    output logic          [$clog2(NSRC+1)-1:0] o_n_valid
);

    localparam int c_NW = $clog2(NSRC+1);

    logic [c_NW-1:0] w_cnt;

    // Running prefix count of valid lanes gives each lane its destination slot.
    always_comb begin
        o_slot = '0;
        w_cnt  = '0;
        for (int l = 0; l < NSRC; l++) begin
            if (i_lane_v[l]) begin
                o_slot[w_cnt] = i_lane[l];
                w_cnt         = w_cnt + c_NW'(1);
            end
        end
        o_n_valid = w_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/qupls_valid_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : qupls_valid_wr_arbiter
// Brief   : Queues valid-bit write events and drains up to NPORT per cycle in
//           age order. Optional: QUPLS_VALARB_BYPASS_EN (empty-queue bypass).
// Revision: 1.0  initial release
// ============================================================================
module qupls_valid_wr_arbiter
    import qupls_valid_wr_arbiter_pkg::*;
#(
    parameter int NSRC   = 12,
    parameter int NPORT  = 8,
    parameter int QDEPTH = 32
) (
    input  logic                          clka,
    input  logic                          rst,
    input  logic         [NSRC-1:0]       req_v,
    input  checkpt_ndx_t [NSRC-1:0]       req_cp,
    input  pregno_t      [NSRC-1:0]       req_pr,
    input  logic         [NSRC-1:0]       req_bit,
    input  logic         [NSRC-1:0]       req_setall,
    output logic                          req_rdy,
    input  logic                          flush_v,
    input  checkpt_ndx_t                  flush_cp,
    output logic         [NPORT-1:0]      wr,
    output checkpt_ndx_t [NPORT-1:0]      wc,
    output pregno_t      [NPORT-1:0]      wa,
    output logic         [NPORT-1:0]      setall,
    output logic         [NPORT-1:0]      i,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

    localparam int c_PW = $clog2(QDEPTH);
    localparam int c_CW = $clog2(QDEPTH+1);
    localparam int c_NW = $clog2(NSRC+1);

    valid_wr_req_t [NSRC-1:0]  w_lane;
    valid_wr_req_t [NSRC-1:0]  w_slot;
    valid_wr_req_t [NPORT-1:0] w_out;
    logic [c_NW-1:0]           w_n_in;
    logic [c_NW-1:0]           w_n_acc;
    logic [c_NW-1:0]           w_n_byp;
    logic [c_NW-1:0]           w_n_enq;
    logic [c_CW-1:0]           w_k;

    valid_wr_req_t             r_q [QDEPTH];
    logic [c_PW-1:0]           r_head;
    logic [c_PW-1:0]           r_tail;
    logic [c_CW-1:0]           r_count;

    logic         [NPORT-1:0]  r_wr;
    checkpt_ndx_t [NPORT-1:0]  r_wc;
    pregno_t      [NPORT-1:0]  r_wa;
    logic         [NPORT-1:0]  r_setall;
    logic         [NPORT-1:0]  r_i;

    // Incoming requests hit by a same-cycle flush still take a slot, as no-ops.
    always_comb begin
        for (int l = 0; l < NSRC; l++) begin
            w_lane[l].vld    = !cp_hit(flush_v, flush_cp, req_cp[l]);
            w_lane[l].cp     = req_cp[l];
            w_lane[l].pr     = req_pr[l];
            w_lane[l].vbit   = req_bit[l];
            w_lane[l].setall = req_setall[l];
        end
    end

    qupls_req_compactor #(
        .NSRC      (NSRC)
    ) u_compact (
        .i_lane_v  (req_v),
        .i_lane    (w_lane),
        .o_slot    (w_slot),
        .o_n_valid (w_n_in)
    );

    assign req_rdy = (r_count <= c_CW'(QDEPTH - NSRC));
    assign w_n_acc = req_rdy ? w_n_in : '0;
    assign w_k     = (r_count > c_CW'(NPORT)) ? c_CW'(NPORT) : r_count;

`ifdef QUPLS_VALARB_BYPASS_EN
    assign w_n_byp = (r_count == '0) ?
                     ((w_n_acc > c_NW'(NPORT)) ? c_NW'(NPORT) : w_n_acc) : '0;
`else
    assign w_n_byp = '0;
`endif
    assign w_n_enq = w_n_acc - w_n_byp;

    // Oldest entry lands on port 0 so higher ports carry younger writes.
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            w_out[j] = '0;
            if (c_CW'(j) < w_k) begin
                w_out[j]     = r_q[r_head + c_PW'(j)];
                w_out[j].vld = w_out[j].vld && !cp_hit(flush_v, flush_cp, w_out[j].cp);
            end
`ifdef QUPLS_VALARB_BYPASS_EN
            else if (c_NW'(j) < w_n_byp) begin
                w_out[j] = w_slot[j];
            end
`endif
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            for (int e = 0; e < QDEPTH; e++)
                r_q[e] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (flush_v) begin
                for (int e = 0; e < QDEPTH; e++)
                    if (r_q[e].cp == flush_cp)
                        r_q[e].vld <= 1'b0;
            end
            for (int s = 0; s < NSRC; s++) begin
                if (c_NW'(s) >= w_n_byp && c_NW'(s) < w_n_acc)
                    r_q[r_tail + c_PW'(s) - c_PW'(w_n_byp)] <= w_slot[s];
            end
            r_head  <= r_head + c_PW'(w_k);
            r_tail  <= r_tail + c_PW'(w_n_enq);
            r_count <= r_count + c_CW'(w_n_enq) - w_k;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_wr     <= '0;
            r_wc     <= '0;
            r_wa     <= '0;
            r_setall <= '0;
            r_i      <= '0;
        end else begin
            for (int j = 0; j < NPORT; j++) begin
                r_wr[j]     <= w_out[j].vld;
                r_wc[j]     <= w_out[j].cp;
                r_wa[j]     <= w_out[j].pr;
                r_setall[j] <= w_out[j].setall && w_out[j].vld;
                r_i[j]      <= w_out[j].vbit;
            end
        end
    end

    assign wr      = r_wr;
    assign wc      = r_wc;
    assign wa      = r_wa;
    assign setall  = r_setall;
    assign i       = r_i;
    assign q_count = r_count;

`ifndef SYNTHESIS
    always_ff @(posedge clka) begin
        if (!rst)
            assert (r_count <= c_CW'(QDEPTH));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qupls_valid_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_qupls_valid_wr_arbiter
// Brief   : Directed self-checking bench for the valid-bit write arbiter.
// Revision: 1.0  initial release
// ============================================================================
module tb_qupls_valid_wr_arbiter;
    import qupls_valid_wr_arbiter_pkg::*;

    localparam int NSRC   = 12;
    localparam int NPORT  = 8;
    localparam int QDEPTH = 32;

    logic                       clka;
    logic                       rst;
    logic         [NSRC-1:0]    req_v;
    checkpt_ndx_t [NSRC-1:0]    req_cp;
    pregno_t      [NSRC-1:0]    req_pr;
    logic         [NSRC-1:0]    req_bit;
    logic         [NSRC-1:0]    req_setall;
    logic                       req_rdy;
    logic                       flush_v;
    checkpt_ndx_t               flush_cp;
    logic         [NPORT-1:0]   wr;
    checkpt_ndx_t [NPORT-1:0]   wc;
    pregno_t      [NPORT-1:0]   wa;
    logic         [NPORT-1:0]   setall;
    logic         [NPORT-1:0]   i;
    logic [$clog2(QDEPTH+1)-1:0] q_count;

    int n_cmp;
    int n_err;
    int n_wr_seen;
    int n_held_seen;

    qupls_valid_wr_arbiter #(
        .NSRC       (NSRC),
        .NPORT      (NPORT),
        .QDEPTH     (QDEPTH)
    ) u_dut (
        .clka       (clka),
        .rst        (rst),
        .req_v      (req_v),
        .req_cp     (req_cp),
        .req_pr     (req_pr),
        .req_bit    (req_bit),
        .req_setall (req_setall),
        .req_rdy    (req_rdy),
        .flush_v    (flush_v),
        .flush_cp   (flush_cp),
        .wr         (wr),
        .wc         (wc),
        .wa         (wa),
        .setall     (setall),
        .i          (i),
        .q_count    (q_count)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and tally every write seen on the ports.
    task automatic tick();
        @(posedge clka);
        #1;
        for (int j = 0; j < NPORT; j++) begin
            if (wr[j]) begin
                n_wr_seen++;
                if (wa[j] >= 9'd200 && wa[j] < 9'd212)
                    n_held_seen++;
            end
        end
    endtask

    task automatic clear_reqs();
        req_v      = '0;
        req_cp     = '0;
        req_pr     = '0;
        req_bit    = '0;
        req_setall = '0;
    endtask

    task automatic set_lane(input int l, input int cp, input int pr, input logic b, input logic sa);
        req_v[l]      = 1'b1;
        req_cp[l]     = checkpt_ndx_t'(cp);
        req_pr[l]     = pregno_t'(pr);
        req_bit[l]    = b;
        req_setall[l] = sa;
    endtask

    task automatic set_all(input int cp, input int pr_base);
        for (int l = 0; l < NSRC; l++)
            set_lane(l, cp, pr_base + l, 1'b1, 1'b0);
    endtask

    initial begin
        logic ram;
        n_cmp = 0; n_err = 0; n_wr_seen = 0; n_held_seen = 0;
        rst = 1'b1; flush_v = 1'b0; flush_cp = '0;
        clear_reqs();
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_wr", 32'(wr), 32'h0);
        chk("reset_count", 32'(q_count), 32'd0);
        chk("reset_rdy", 32'(req_rdy), 32'd1);

        // Single request through the queue
        set_lane(0, 2, 5, 1'b1, 1'b0);
        tick();
        clear_reqs();
        chk("single_count_q", 32'(q_count), 32'd1);
        chk("single_wr_early", 32'(wr), 32'h0);
        tick();
        chk("single_wr", 32'(wr), 32'h01);
        chk("single_wc0", 32'(wc[0]), 32'd2);
        chk("single_wa0", 32'(wa[0]), 32'd5);
        chk("single_i", 32'(i), 32'h01);
        chk("single_count_0", 32'(q_count), 32'd0);
        tick();
        chk("single_idle", 32'(wr), 32'h0);

        // All 12 sources, bit = l&1, source 2 is a setall
        for (int l = 0; l < NSRC; l++)
            set_lane(l, 1, 16 + l, 1'(l & 1), (l == 2));
        tick();
        clear_reqs();
        chk("all12_count", 32'(q_count), 32'd12);
        tick();
        chk("all12_wr_a", 32'(wr), 32'hFF);
        chk("all12_wa0", 32'(wa[0]), 32'd16);
        chk("all12_wa7", 32'(wa[7]), 32'd23);
        chk("all12_i_a", 32'(i), 32'hAA);
        chk("all12_setall", 32'(setall), 32'h04);
        chk("all12_count_4", 32'(q_count), 32'd4);
        tick();
        chk("all12_wr_b", 32'(wr), 32'h0F);
        chk("all12_wa0_b", 32'(wa[0]), 32'd24);
        chk("all12_wa3_b", 32'(wa[3]), 32'd27);
        chk("all12_i_b", 32'(i), 32'h0A);
        chk("all12_setall_b", 32'(setall), 32'h00);
        chk("all12_count_0", 32'(q_count), 32'd0);

        // Same-address conflict: source 7 must land on the higher port
        set_lane(3, 1, 9, 1'b0, 1'b0);
        set_lane(7, 1, 9, 1'b1, 1'b0);
        tick();
        clear_reqs();
        tick();
        chk("conflict_wr", 32'(wr), 32'h03);
        chk("conflict_i", 32'(i), 32'h02);
        ram = 1'b0;
        for (int j = 0; j < NPORT; j++)
            if (wr[j] && wc[j] == checkpt_ndx_t'(1) && wa[j] == pregno_t'(9))
                ram = i[j];
        chk("conflict_ram", 32'(ram), 32'd1);
        tick(); tick();

        // Fill to 21, hold a tagged batch while req_rdy=0
        n_wr_seen = 0; n_held_seen = 0;
        set_all(5, 100);
        tick();
        chk("fill_12", 32'(q_count), 32'd12);
        tick();
        chk("fill_16", 32'(q_count), 32'd16);
        tick();
        chk("fill_20", 32'(q_count), 32'd20);
        chk("fill_rdy20", 32'(req_rdy), 32'd1);
        clear_reqs();
        for (int l = 0; l < 9; l++)
            set_lane(l, 5, 120 + l, 1'b1, 1'b0);
        tick();
        chk("fill_21", 32'(q_count), 32'd21);
        chk("fill_rdy21", 32'(req_rdy), 32'd0);
        clear_reqs();
        set_all(6, 200);
        tick();
        chk("held_ignored", 32'(q_count), 32'd13);
        chk("held_rdy", 32'(req_rdy), 32'd1);
        tick();
        chk("held_accepted", 32'(q_count), 32'd17);
        clear_reqs();
        tick(); tick(); tick(); tick();
        chk("fill_drained", 32'(q_count), 32'd0);
        chk("held_once", 32'(n_held_seen), 32'd12);
        chk("fill_total_wr", 32'(n_wr_seen), 32'd57);

        // Flush cp=4: sources 0-5 cp=4, 6-11 cp=3; plus an incoming cp=4 no-op
        for (int l = 0; l < NSRC; l++)
            set_lane(l, (l < 6) ? 4 : 3, 50 + l, 1'b1, 1'b0);
        tick();
        chk("flush_count12", 32'(q_count), 32'd12);
        clear_reqs();
        set_lane(0, 4, 77, 1'b1, 1'b0);
        flush_v = 1'b1; flush_cp = checkpt_ndx_t'(4);
        tick();
        clear_reqs();
        flush_v = 1'b0;
        chk("flush_wr_a", 32'(wr), 32'hC0);
        chk("flush_wa6", 32'(wa[6]), 32'd56);
        chk("flush_count5", 32'(q_count), 32'd5);
        tick();
        chk("flush_wr_b", 32'(wr), 32'h0F);
        chk("flush_wa4", 32'(wa[4]), 32'd77);
        chk("flush_count0", 32'(q_count), 32'd0);
        tick();

        // Reset with 20 entries queued
        set_all(7, 300);
        tick(); tick(); tick();
        chk("midrst_count20", 32'(q_count), 32'd20);
        clear_reqs();
        rst = 1'b1;
        tick();
        chk("midrst_wr", 32'(wr), 32'h0);
        chk("midrst_count", 32'(q_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("postrst_wr", 32'(wr), 32'h0);
        chk("postrst_count", 32'(q_count), 32'd0);
        chk("postrst_rdy", 32'(req_rdy), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("postrst_stale", 32'(wr), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
